// File: rtl/except_ctrl_pkg.sv
// Shared definitions for the exception controller: CP0 addresses, exception codes,
// trap vector and FSM state type. Optional trap support is enabled with EXC_TRAP_EN.
package except_ctrl_pkg;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  localparam logic [31:0] EXC_NONE    = 32'h0000_0000;
  localparam logic [31:0] EXC_INT     = 32'h0000_0001;
  localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
  localparam logic [31:0] EXC_INVALID = 32'h0000_000a;
  localparam logic [31:0] EXC_OV      = 32'h0000_000c;
  localparam logic [31:0] EXC_TRAP    = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET    = 32'h0000_000e;

  localparam logic [31:0] EXC_VECTOR = 32'h0000_0020;

  // Only the software-writable CAUSE fields (IP[1:0], IV, WP) take an mtc0 write.
  localparam logic [31:0] CAUSE_WR_MASK = 32'h00c0_0300;

  // Bit positions inside the raw exception flag vector.
  localparam int FLAG_SYSCALL = 0;
  localparam int FLAG_INVALID = 1;
  localparam int FLAG_TRAP    = 2;
  localparam int FLAG_OV      = 3;
  localparam int FLAG_ERET    = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

endpackage

// File: rtl/except_ctrl_cp0_fwd.sv
// Bypass of an in-flight WB-stage mtc0 onto the STATUS/CAUSE/EPC values seen by
// the exception controller, so decisions use the architecturally newest state.
module cp0_fwd
  import except_ctrl_pkg::*;
(
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_data_i,
  output logic [31:0] fwd_status,
  output logic [31:0] fwd_cause,
  output logic [31:0] fwd_epc
);

  // NOTE: every output gets a default before any condition so no latch is inferred.
  always_comb begin
    fwd_status = cp0_status_i;
    fwd_cause  = cp0_cause_i;
    fwd_epc    = cp0_epc_i;
    if (wb_cp0_we_i) begin
      unique case (wb_cp0_waddr_i)
        CP0_STATUS: fwd_status = wb_cp0_data_i;
        CP0_CAUSE:  fwd_cause  = (cp0_cause_i & ~CAUSE_WR_MASK) | (wb_cp0_data_i & CAUSE_WR_MASK);
        CP0_EPC:    fwd_epc    = wb_cp0_data_i;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/except_ctrl.sv
// MEM-stage exception controller: prioritises interrupt/exception sources, then
// issues a one-cycle flush with redirect PC. Trap source compiled in with EXC_TRAP_EN.
module except_ctrl
  import except_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid_i,
  input  logic [4:0]  mem_exc_flags_i,
  input  logic [31:0] mem_inst_addr_i,
  input  logic        mem_in_delayslot_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_data_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] cur_inst_addr_o,
  output logic        is_in_delayslot_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o
);

  logic [31:0] fwd_status, fwd_cause, fwd_epc;

  cp0_fwd u_cp0_fwd (
    .cp0_status_i   (cp0_status_i),
    .cp0_cause_i    (cp0_cause_i),
    .cp0_epc_i      (cp0_epc_i),
    .wb_cp0_we_i    (wb_cp0_we_i),
    .wb_cp0_waddr_i (wb_cp0_waddr_i),
    .wb_cp0_data_i  (wb_cp0_data_i),
    .fwd_status     (fwd_status),
    .fwd_cause      (fwd_cause),
    .fwd_epc        (fwd_epc)
  );

  logic unused_fwd;
  assign unused_fwd = ^{fwd_status[31:16], fwd_status[7:2], fwd_cause[31:16], fwd_cause[7:0]};

  logic int_pending;
  logic trap_hit;

  assign int_pending = mem_valid_i && ((fwd_cause[15:8] & fwd_status[15:8]) != 8'h00)
                       && fwd_status[0] && !fwd_status[1];

`ifdef EXC_TRAP_EN
  assign trap_hit = mem_exc_flags_i[FLAG_TRAP];
`else
  logic unused_trap;
  assign unused_trap = mem_exc_flags_i[FLAG_TRAP];
  assign trap_hit    = 1'b0;
`endif

  logic [31:0] exc_code;

  always_comb begin
    exc_code = EXC_NONE;
    if (!mem_valid_i)                          exc_code = EXC_NONE;
    else if (int_pending)                      exc_code = EXC_INT;
    else if (mem_exc_flags_i[FLAG_SYSCALL])    exc_code = EXC_SYSCALL;
    else if (mem_exc_flags_i[FLAG_INVALID])    exc_code = EXC_INVALID;
    else if (trap_hit)                         exc_code = EXC_TRAP;
    else if (mem_exc_flags_i[FLAG_OV])         exc_code = EXC_OV;
    else if (mem_exc_flags_i[FLAG_ERET])       exc_code = EXC_ERET;
  end

  state_t      state, state_next;
  logic [31:0] code_next, addr_next, new_pc_next;
  logic        slot_next;

  // In FLUSH the inputs belong to an instruction being squashed, so they are ignored.
  always_comb begin
    state_next  = state;
    code_next   = EXC_NONE;
    addr_next   = 32'h0;
    slot_next   = 1'b0;
    new_pc_next = 32'h0;
    unique case (state)
      ST_IDLE: begin
        if (exc_code != EXC_NONE) begin
          state_next  = ST_FLUSH;
          code_next   = exc_code;
          addr_next   = mem_inst_addr_i;
          slot_next   = mem_in_delayslot_i;
          new_pc_next = (exc_code == EXC_ERET) ? fwd_epc : EXC_VECTOR;
        end
      end
      ST_FLUSH: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // NOTE: state and registered outputs use non-blocking assignments so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= ST_IDLE;
      excepttype_o      <= EXC_NONE;
      cur_inst_addr_o   <= 32'h0;
      is_in_delayslot_o <= 1'b0;
      new_pc_o          <= 32'h0;
    end else begin
      state             <= state_next;
      excepttype_o      <= code_next;
      cur_inst_addr_o   <= addr_next;
      is_in_delayslot_o <= slot_next;
      new_pc_o          <= new_pc_next;
    end
  end

  assign flush_o = (state == ST_FLUSH);

endmodule

// File: tb/tb_except_ctrl.sv
// Scoreboard bench for except_ctrl: directed corner cases then random traffic
// predicted by a priority-table reference model.
module tb_except_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid_i;
  logic [4:0]  mem_exc_flags_i;
  logic [31:0] mem_inst_addr_i;
  logic        mem_in_delayslot_i;
  logic [31:0] cp0_status_i, cp0_cause_i, cp0_epc_i;
  logic        wb_cp0_we_i;
  logic [4:0]  wb_cp0_waddr_i;
  logic [31:0] wb_cp0_data_i;
  logic [31:0] excepttype_o, cur_inst_addr_o, new_pc_o;
  logic        is_in_delayslot_o, flush_o;

  except_ctrl dut (
    .clk                (clk),
    .rst                (rst),
    .mem_valid_i        (mem_valid_i),
    .mem_exc_flags_i    (mem_exc_flags_i),
    .mem_inst_addr_i    (mem_inst_addr_i),
    .mem_in_delayslot_i (mem_in_delayslot_i),
    .cp0_status_i       (cp0_status_i),
    .cp0_cause_i        (cp0_cause_i),
    .cp0_epc_i          (cp0_epc_i),
    .wb_cp0_we_i        (wb_cp0_we_i),
    .wb_cp0_waddr_i     (wb_cp0_waddr_i),
    .wb_cp0_data_i      (wb_cp0_data_i),
    .excepttype_o       (excepttype_o),
    .cur_inst_addr_o    (cur_inst_addr_o),
    .is_in_delayslot_o  (is_in_delayslot_o),
    .flush_o            (flush_o),
    .new_pc_o           (new_pc_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          valid;
    logic [4:0]  flags;
    logic [31:0] pc;
    bit          slot;
    logic [31:0] status, cause, epc;
    bit          we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } stim_t;

  typedef struct {
    logic [31:0] code;
    logic [31:0] pc;
    logic        slot;
    logic [31:0] new_pc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   busy     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic stim_t mk(bit valid, logic [4:0] flags, logic [31:0] pc, bit slot,
                               logic [31:0] status, logic [31:0] cause, logic [31:0] epc);
    stim_t s;
    s.valid = valid; s.flags = flags; s.pc = pc; s.slot = slot;
    s.status = status; s.cause = cause; s.epc = epc;
    s.we = 0; s.waddr = 5'd0; s.wdata = 32'h0;
    return s;
  endfunction

  // Reference: newest CP0 view, then first active source in the priority table.
  function automatic bit predict(stim_t s, output exp_t e);
    logic [31:0] st, ca, ep;
    logic [31:0] codes[6];
    bit          act[6];
    st = s.status; ca = s.cause; ep = s.epc;
    if (s.we && s.waddr == 5'd12) st = s.wdata;
    if (s.we && s.waddr == 5'd13) begin
      ca[9:8] = s.wdata[9:8];
      ca[23]  = s.wdata[23];
      ca[22]  = s.wdata[22];
    end
    if (s.we && s.waddr == 5'd14) ep = s.wdata;
    codes = '{32'h01, 32'h08, 32'h0a, 32'h0d, 32'h0c, 32'h0e};
    act[0] = ((ca[15:8] & st[15:8]) != 0) && st[0] && !st[1];
    act[1] = s.flags[0];
    act[2] = s.flags[1];
`ifdef EXC_TRAP_EN
    act[3] = s.flags[2];
`else
    act[3] = 0;
`endif
    act[4] = s.flags[3];
    act[5] = s.flags[4];
    e = '{32'h0, 32'h0, 1'b0, 32'h0};
    if (!s.valid) return 0;
    for (int i = 0; i < 6; i++) begin
      if (act[i]) begin
        e.code   = codes[i];
        e.pc     = s.pc;
        e.slot   = s.slot;
        e.new_pc = (codes[i] == 32'h0e) ? ep : 32'h20;
        return 1;
      end
    end
    return 0;
  endfunction

  // Drive one cycle of inputs; an accepted exception appears after the next edge.
  task automatic apply(input stim_t s);
    exp_t e;
    bit   hit;
    mem_valid_i        = s.valid;
    mem_exc_flags_i    = s.flags;
    mem_inst_addr_i    = s.pc;
    mem_in_delayslot_i = s.slot;
    cp0_status_i       = s.status;
    cp0_cause_i        = s.cause;
    cp0_epc_i          = s.epc;
    wb_cp0_we_i        = s.we;
    wb_cp0_waddr_i     = s.waddr;
    wb_cp0_data_i      = s.wdata;
    hit = predict(s, e) && !busy;
    @(posedge clk);
    if (hit) exp_q.push_back(e);
    busy = hit;
    #1;
  endtask

  // Monitor: a queued entry means a flush pulse is due now; otherwise all outputs idle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("flush_pulse", {31'h0, flush_o}, 32'h1);
        check("excepttype", excepttype_o, e.code);
        check("cur_inst_addr", cur_inst_addr_o, e.pc);
        check("in_delayslot", {31'h0, is_in_delayslot_o}, {31'h0, e.slot});
        check("new_pc", new_pc_o, e.new_pc);
      end else begin
        check("idle_outputs",
              {31'h0, flush_o | is_in_delayslot_o} | excepttype_o | cur_inst_addr_o | new_pc_o,
              32'h0);
      end
    end
  end

  initial begin
    stim_t idle, s;
    idle = mk(0, 5'b0, 32'h0, 0, 32'h0, 32'h0, 32'h0);
    rst = 1'b0;
    apply_inputs_only(idle);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Syscall at 0x100 outside a delay slot, then idle.
    apply(mk(1, 5'b00001, 32'h100, 0, 32'h0, 32'h0, 32'h0));
    apply(idle);
    apply(idle);

    // Enabled interrupt fires; same with EXL set is masked.
    apply(mk(1, 5'b0, 32'h180, 0, 32'h0000_0401, 32'h0000_0400, 32'h0));
    apply(idle);
    apply(mk(1, 5'b0, 32'h184, 0, 32'h0000_0403, 32'h0000_0400, 32'h0));
    apply(idle);

    // ERET takes EPC forwarded from a same-cycle WB write.
    s = mk(1, 5'b10000, 32'h1f0, 0, 32'h0, 32'h0, 32'h200);
    s.we = 1; s.waddr = 5'd14; s.wdata = 32'h300;
    apply(s);
    apply(idle);

    // Interrupt unmasked only through a forwarded STATUS write.
    s = mk(1, 5'b0, 32'h1f4, 1, 32'h0, 32'h0000_0100, 32'h0);
    s.we = 1; s.waddr = 5'd12; s.wdata = 32'h0000_0101;
    apply(s);
    apply(idle);

    // Priority among simultaneous flags, and ov in a delay slot.
    apply(mk(1, 5'b01011, 32'h108, 0, 32'h0, 32'h0, 32'h0));
    apply(idle);
    apply(mk(1, 5'b01000, 32'h104, 1, 32'h0, 32'h0, 32'h0));
    apply(idle);

    // Flags with valid low are ignored.
    apply(mk(0, 5'b11111, 32'h10c, 0, 32'h0, 32'h0, 32'h0));
    apply(idle);

    // Trap alone: code 0x0d only when the trap source is built in.
    apply(mk(1, 5'b00100, 32'h110, 0, 32'h0, 32'h0, 32'h0));
    apply(idle);
    apply(mk(1, 5'b10100, 32'h114, 0, 32'h0, 32'h0, 32'h280));
    apply(idle);

    // Back-to-back requests produce a single pulse.
    apply(mk(1, 5'b00001, 32'h120, 0, 32'h0, 32'h0, 32'h0));
    apply(mk(1, 5'b00010, 32'h124, 0, 32'h0, 32'h0, 32'h0));
    apply(idle);
    apply(idle);

    // Reset asserted during FLUSH clears outputs immediately; no pulse afterwards.
    apply(mk(1, 5'b00001, 32'h130, 1, 32'h0, 32'h0, 32'h0));
    rst = 1'b0;
    #1;
    check("rst_flush", {31'h0, flush_o}, 32'h0);
    check("rst_excepttype", excepttype_o, 32'h0);
    check("rst_new_pc", new_pc_o, 32'h0);
    check("rst_cur_addr", cur_inst_addr_o, 32'h0);
    check("rst_slot", {31'h0, is_in_delayslot_o}, 32'h0);
    exp_q.delete();
    busy = 0;
    apply_inputs_only(idle);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) apply(idle);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      s.valid  = ($urandom_range(0, 3) != 0);
      s.flags  = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'b0;
      s.pc     = $urandom & 32'hffff_fffc;
      s.slot   = $urandom_range(0, 1) == 1;
      s.status = {$urandom} & 32'h0000_ff03;
      s.cause  = {$urandom} & 32'h00c0_ff00;
      s.epc    = $urandom;
      s.we     = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 3))
        0:       s.waddr = 5'd12;
        1:       s.waddr = 5'd13;
        2:       s.waddr = 5'd14;
        default: s.waddr = 5'($urandom);
      endcase
      s.wdata  = $urandom;
      apply(s);
    end
    repeat (3) apply(idle);

    check("queue_drained", exp_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  task automatic apply_inputs_only(input stim_t s);
    mem_valid_i        = s.valid;
    mem_exc_flags_i    = s.flags;
    mem_inst_addr_i    = s.pc;
    mem_in_delayslot_i = s.slot;
    cp0_status_i       = s.status;
    cp0_cause_i        = s.cause;
    cp0_epc_i          = s.epc;
    wb_cp0_we_i        = s.we;
    wb_cp0_waddr_i     = s.waddr;
    wb_cp0_data_i      = s.wdata;
  endtask

endmodule
